// File: rtl/rpc2_psram_bridge_v2.sv
// RPC2 transaction/TX/RX <-> PSRAM controller bridge with an explicit request FSM,
// a first-word-fall-through RX elastic FIFO, stall timeout and overflow tracking.
module rpc2_psram_bridge_v2 #(
  parameter int LEN_W         = 9,
  parameter int RX_ADDR_WIDTH = 1,
  parameter int RX_FIFO_DEPTH = 8,
  parameter int TO_CYCLES     = 31
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rpc2_rw_valid,
  output logic                     rpc2_rw_ready,
  input  logic                     rpc2_rw_n,
  input  logic                     rpc2_target,
  input  logic                     rpc2_type,
  input  logic                     rpc2_gb_rst,
  input  logic                     rpc2_mem_init,
  input  logic [30:0]              rpc2_address,
  input  logic [LEN_W-1:0]         rpc2_len,
  input  logic [1:0]               rpc2_error,
  input  logic                     rpc2_done_request,
  output logic                     rpc2_wr_done,
  input  logic [15:0]              tx_data,
  input  logic [1:0]               tx_mask,
  input  logic                     tx_data_valid,
  output logic                     tx_data_ready,
  output logic [15:0]              rx_data,
  output logic                     rx_data_valid,
  input  logic                     rx_data_ready,
  output logic                     rx_data_last,
  output logic [RX_ADDR_WIDTH-1:0] rx_data_addr,
  output logic [1:0]               rx_error,
  output logic                     rx_stall,
  output logic                     rx_overflow,
  output logic                     bd_instruction_req,
  input  logic                     bd_instruction_ready,
  output logic [7:0]               bd_command,
  output logic [31:0]              bd_address,
  output logic [LEN_W-1:0]         bd_data_len,
  output logic [15:0]              bd_wdata,
  output logic [1:0]               bd_wdata_mask,
  input  logic                     bd_wdata_ready,
  input  logic                     bd_rdata_valid,
  input  logic [15:0]              bd_rdata
);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = LEN_W + 1;
  localparam logic [7:0] TO_VAL = 8'(TO_CYCLES);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t            state_q, state_d;
  logic              rw_n_q, rw_n_d;
  logic [7:0]        cmd_q, cmd_d, cmd_dec, core;
  logic [30:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        err_q, err_d;
  logic              done_req_q, done_req_d;
  logic              req_q, req_d;
  logic              wr_done_q, wr_done_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     wcnt_q, wcnt_d, pcnt_q, pcnt_d, popc_q, popc_d;
  logic [7:0]        to_q, to_d;
  logic [AW:0]       wp_q, wp_d, rp_q, rp_d;
  logic [15:0]       fifo_mem [RX_FIFO_DEPTH];

  logic [CW-1:0] len_ext;
  logic          empty, full, pop, push_req, wr_en, wbeat;

  assign len_ext  = {1'b0, len_q};
  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop      = ~empty & rx_data_ready;
  // Pulses past the final beat are ignored; a full FIFO only takes a beat if one leaves
  assign push_req = (state_q == RDATA) & bd_rdata_valid & (pcnt_q <= len_ext);
  assign wr_en    = push_req & (~full | pop);
  assign wbeat    = (state_q == WDATA) & tx_data_valid & bd_wdata_ready;

  always_comb begin
    core = {~rpc2_rw_n, rpc2_target, ~rpc2_type, 3'b000, rpc2_gb_rst, rpc2_mem_init};
    case (core)
      8'hC1:   cmd_dec = 8'h00;
      8'hC2:   cmd_dec = 8'h80;
      8'hC0:   cmd_dec = 8'h01;
      8'h40:   cmd_dec = 8'h02;
      8'h80:   cmd_dec = 8'h04;
      8'h00:   cmd_dec = 8'h08;
      default: cmd_dec = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rw_n_d     = rw_n_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    len_d      = len_q;
    err_d      = err_q;
    done_req_d = done_req_q;
    req_d      = req_q;
    wr_done_d  = 1'b0;
    ovf_d      = ovf_q;
    wcnt_d     = wcnt_q;
    pcnt_d     = pcnt_q;
    popc_d     = popc_q;
    wp_d       = wr_en ? wp_q + 1'b1 : wp_q;
    rp_d       = pop   ? rp_q + 1'b1 : rp_q;
    case (state_q)
      IDLE: begin
        wp_d = '0;
        rp_d = '0;
        if (rpc2_rw_valid) begin
          rw_n_d     = rpc2_rw_n;
          cmd_d      = cmd_dec;
          addr_d     = rpc2_address;
          len_d      = rpc2_len;
          err_d      = rpc2_error;
          done_req_d = rpc2_done_request;
          ovf_d      = 1'b0;
          wcnt_d     = '0;
          pcnt_d     = '0;
          popc_d     = '0;
          req_d      = 1'b1;
          state_d    = CMD;
        end
      end
      CMD: begin
        if (bd_instruction_ready) begin
          req_d   = 1'b0;
          state_d = rw_n_q ? RDATA : WDATA;
        end
      end
      WDATA: begin
        if (wbeat) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == len_ext) begin
            state_d   = IDLE;
            wr_done_d = done_req_q;
          end
        end
      end
      RDATA: begin
        if (push_req) begin
          pcnt_d = pcnt_q + 1'b1;
          if (full & ~pop) ovf_d = 1'b1;
        end
        if (pop) begin
          popc_d = popc_q + 1'b1;
          if (popc_q == len_ext) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall timer restarts on every pop and whenever no read is in progress
  always_comb begin
    to_d = to_q;
    if (state_q != RDATA || pop)
      to_d = '0;
    else if (~empty & ~rx_data_ready & (to_q != TO_VAL))
      to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rw_n_q     <= 1'b0;
      cmd_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      err_q      <= '0;
      done_req_q <= 1'b0;
      req_q      <= 1'b0;
      wr_done_q  <= 1'b0;
      ovf_q      <= 1'b0;
      wcnt_q     <= '0;
      pcnt_q     <= '0;
      popc_q     <= '0;
      to_q       <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
    end else begin
      state_q    <= state_d;
      rw_n_q     <= rw_n_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      err_q      <= err_d;
      done_req_q <= done_req_d;
      req_q      <= req_d;
      wr_done_q  <= wr_done_d;
      ovf_q      <= ovf_d;
      wcnt_q     <= wcnt_d;
      pcnt_q     <= pcnt_d;
      popc_q     <= popc_d;
      to_q       <= to_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wp_q[AW-1:0]] <= bd_rdata;
  end

  assign rpc2_rw_ready      = (state_q == IDLE);
  assign rpc2_wr_done       = wr_done_q;
  assign tx_data_ready      = (state_q == WDATA) & bd_wdata_ready;
  assign rx_data_valid      = ~empty;
  assign rx_data            = empty ? 16'h0 : fifo_mem[rp_q[AW-1:0]];
  assign rx_data_last       = ~empty & (popc_q == len_ext);
  assign rx_data_addr       = addr_q[RX_ADDR_WIDTH-1:0] + popc_q[RX_ADDR_WIDTH-1:0];
  assign rx_error           = empty ? 2'b00 : err_q;
  assign rx_stall           = (to_q == TO_VAL);
  assign rx_overflow        = ovf_q;
  assign bd_instruction_req = req_q;
  assign bd_command         = cmd_q;
  assign bd_address         = {1'b0, addr_q};
  assign bd_data_len        = len_q;
  assign bd_wdata           = tx_data;
  assign bd_wdata_mask      = tx_mask;
endmodule
